ysyx22041405_wb_stage: RTL and testbench
========================================

Name: ysyx22041405_wb_stage

Overview:
Registered, parametrised writeback stage between LSU and register file. Captures one LS→WB packet per cycle under valid/ready handshake. Performs load-data extraction (byte/half/word/dword, sign/zero extension, byte-offset alignment) and drives RF write, forwarding and commit/debug ports. Tracks retired-instruction count and enters a halt state on ebreak, illegal instruction or misaligned load, replacing the previous purely combinational WB with its DPI-style halting.

Parameters:
XLEN, 32, datapath width (32 or 64)
PC_W, 32, PC/instruction width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ls_valid  in  1  LS packet valid
wb_ready  out  1  WB accepts packet this cycle
ls_pc  in  PC_W  instruction PC
ls_inst  in  32  instruction word
ls_rf_we  in  1  instruction writes rd
ls_rf_waddr  in  5  rd
ls_alu_res  in  XLEN  non-load result
ls_is_load  in  1  select load path
ls_mem_op  in  3  funct3 load type
ls_addr_lo  in  3  load address low bits
ls_dm_rdata  in  XLEN  raw aligned memory word
ls_ebreak  in  1  instruction is ebreak
ls_inst_valid  in  1  instruction decoded legally
rf_we  out  1  RF write enable
rf_waddr  out  5  RF write address
rf_wdata  out  XLEN  RF write data
fwd_valid  out  1  forwarding entry valid (equals rf_we)
commit_valid  out  1  one instruction retired this cycle
commit_pc  out  PC_W  retired PC
commit_inst  out  32  retired instruction
retired_cnt  out  CNT_W  retired-instruction count
halted  out  1  stage halted
halt_reason  out  2  01 ebreak, 10 illegal, 11 misaligned, 00 none

Behaviour:
- Reset values: all outputs 0, state RUN, internal valid register 0. Reset mid-HALT returns to RUN with counter cleared.
- States: RUN, HALT. wb_ready = (state==RUN). In HALT, inputs are ignored.
- Accept: ls_valid && wb_ready. Packet registered; outputs valid exactly one cycle later, for one cycle only (no stall inside WB). Back-to-back accepts give one commit per cycle.
- Load extract: shift ls_dm_rdata right by 8*ls_addr_lo (XLEN=32 uses addr_lo[1:0]). mem_op 000 LB sext8, 001 LH sext16, 010 LW sext32, 100 LBU, 101 LHU, 110 LWU (XLEN=64 only), 011 LD (XLEN=64 only). Other codes, or 64-bit-only codes at XLEN=32, are treated as illegal.
- Misaligned: half with addr_lo[0]=1; word with addr_lo[1:0]≠0; dword with addr_lo≠0.
- rf_wdata = ls_is_load ? extracted : ls_alu_res. rf_we = registered ls_rf_we && waddr≠0 && no fault && !ebreak.
- Fault priority (registered packet): illegal (!ls_inst_valid && inst≠0) > misaligned > ebreak. On any of these: rf_we=0, state→HALT the next cycle, halt_reason latched, halted=1 until reset.
- commit_valid=1 for every registered packet with inst≠0, except illegal/misaligned. An ebreak commits.
- retired_cnt increments on commit_valid and wraps modulo 2^CNT_W.
- A bubble (inst==0) produces no commit and no write.

Decomposition:
- Shared package/header: XLEN default, mem_op encodings (LB..LWU), halt_reason codes, state encoding.
- One sub-module: ysyx22041405_load_extract (combinational: rdata, addr_lo, mem_op → data, misaligned, bad_op).

Test Plan:
- LB at addr_lo=3, rdata=0x80FF_1234, rd=5 → cycle+1: rf_we=1, waddr=5, wdata=0xFFFF_FF80, commit_valid=1, retired_cnt=1.
- LHU at addr_lo=2, rdata=0xBEEF_0000 → wdata=0x0000_BEEF. LH at addr_lo=1 → rf_we=0, halted=1, halt_reason=11, wb_ready=0.
- 4 back-to-back ALU packets rd=0,1,2,3 → 4 commits, rf_we only for rd 1..3, retired_cnt=4.
- ebreak packet followed by valid ALU packet → ebreak commits, halt_reason=01, second packet not accepted (wb_ready=0), count unchanged.
- ls_inst_valid=0, inst=0x0000_FFFF → no commit, halt_reason=10. Then rst for one cycle → all outputs 0, wb_ready=1.
- XLEN=64: LD addr_lo=0, rdata=0x8000_0000_0000_0001 → wdata identical. LWU → 0x0000_0000_0000_0001.

Source files
------------

// File: rtl/ysyx22041405_wb_stage_pkg.sv
// Shared definitions for the writeback stage.
// Contents: default datapath width, load funct3 encodings, halt-reason
// codes, FSM state encoding and a small fault-reason helper.
package ysyx22041405_wb_stage_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Load funct3 encodings
  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [2:0] OP_LWU = 3'b110;

  typedef enum logic [1:0] {
    HR_NONE     = 2'b00,
    HR_EBREAK   = 2'b01,
    HR_ILLEGAL  = 2'b10,
    HR_MISALIGN = 2'b11
  } halt_reason_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // Resolve simultaneous fault flags into one reason, highest priority first.
  function automatic halt_reason_e fault_reason(input logic illegal,
                                                input logic misalign,
                                                input logic ebreak);
    halt_reason_e r;
    if (illegal) begin
      r = HR_ILLEGAL;
    end else if (misalign) begin
      r = HR_MISALIGN;
    end else if (ebreak) begin
      r = HR_EBREAK;
    end else begin
      r = HR_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/ysyx22041405_load_extract.sv
// Combinational load-data extraction.
// Ports:
//   rdata_i      raw aligned memory word
//   addr_lo_i    byte offset of the load inside the word
//   mem_op_i     load funct3
//   data_o       aligned, sign/zero-extended load result
//   misaligned_o access crosses its natural alignment
//   bad_op_o     funct3 is not a load supported at this XLEN
module ysyx22041405_load_extract
  import ysyx22041405_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [2:0]      mem_op_i,
  output logic [XLEN-1:0] data_o,
  output logic            misaligned_o,
  output logic            bad_op_o
);

  localparam bit IS64 = (XLEN == 64);

  logic [2:0]      byte_off_s;
  logic [XLEN-1:0] shifted_s;

  // Shift the addressed bytes down to bit 0, then extend by load type.
  always_comb begin
    // On a 32-bit datapath only the low two offset bits select a byte.
    byte_off_s   = IS64 ? addr_lo_i : {1'b0, addr_lo_i[1:0]};
    shifted_s    = rdata_i >> {byte_off_s, 3'b000};
    data_o       = '0;
    misaligned_o = 1'b0;
    bad_op_o     = 1'b0;
    case (mem_op_i)
      OP_LB:  data_o = XLEN'($signed(shifted_s[7:0]));
      OP_LBU: data_o = XLEN'(shifted_s[7:0]);
      OP_LH: begin
        data_o       = XLEN'($signed(shifted_s[15:0]));
        misaligned_o = addr_lo_i[0];
      end
      OP_LHU: begin
        data_o       = XLEN'(shifted_s[15:0]);
        misaligned_o = addr_lo_i[0];
      end
      OP_LW: begin
        data_o       = XLEN'($signed(shifted_s[31:0]));
        misaligned_o = (addr_lo_i[1:0] != 2'b00);
      end
      OP_LWU: begin
        if (IS64) begin
          data_o       = XLEN'(shifted_s[31:0]);
          misaligned_o = (addr_lo_i[1:0] != 2'b00);
        end else begin
          bad_op_o = 1'b1;
        end
      end
      OP_LD: begin
        if (IS64) begin
          data_o       = shifted_s;
          misaligned_o = (addr_lo_i != 3'b000);
        end else begin
          bad_op_o = 1'b1;
        end
      end
      default: bad_op_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx22041405_wb_stage.sv
// Registered writeback stage between LSU and register file.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ls_* / wb_ready          LS->WB packet with valid/ready handshake
//   rf_we/rf_waddr/rf_wdata  register-file write port
//   fwd_valid                forwarding entry valid (mirrors rf_we)
//   commit_*                 retirement/debug port
//   retired_cnt              retired-instruction counter (wraps)
//   halted/halt_reason       sticky halt after ebreak, illegal or misaligned
// All outputs are registered; a packet accepted at one edge appears on the
// outputs for exactly the following cycle.
module ysyx22041405_wb_stage
  import ysyx22041405_wb_stage_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEFAULT,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ls_valid,
  output logic             wb_ready,
  input  logic [PC_W-1:0]  ls_pc,
  input  logic [31:0]      ls_inst,
  input  logic             ls_rf_we,
  input  logic [4:0]       ls_rf_waddr,
  input  logic [XLEN-1:0]  ls_alu_res,
  input  logic             ls_is_load,
  input  logic [2:0]       ls_mem_op,
  input  logic [2:0]       ls_addr_lo,
  input  logic [XLEN-1:0]  ls_dm_rdata,
  input  logic             ls_ebreak,
  input  logic             ls_inst_valid,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic             commit_valid,
  output logic [PC_W-1:0]  commit_pc,
  output logic [31:0]      commit_inst,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             halted,
  output logic [1:0]       halt_reason
);

  state_e          state_q, state_d;
  halt_reason_e    halt_reason_q, reason_s;
  logic            rf_we_q, commit_q;
  logic [4:0]      waddr_q;
  logic [XLEN-1:0] wdata_q, wdata_s, ld_data_s;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     inst_q;
  logic [CNT_W-1:0] cnt_q;
  logic            misaligned_s, bad_op_s;
  logic            accept_s, bubble_s, illegal_s, misalign_s, ebreak_s;
  logic            commit_s, we_s;

  ysyx22041405_load_extract #(.XLEN(XLEN)) u_load_extract (
    .rdata_i      (ls_dm_rdata),
    .addr_lo_i    (ls_addr_lo),
    .mem_op_i     (ls_mem_op),
    .data_o       (ld_data_s),
    .misaligned_o (misaligned_s),
    .bad_op_o     (bad_op_s)
  );

  // Classify the incoming packet and build its writeback/commit values.
  always_comb begin
    accept_s   = ls_valid && (state_q == ST_RUN);
    bubble_s   = (ls_inst == 32'd0);
    // An unsupported load funct3 counts as an illegal instruction.
    illegal_s  = !bubble_s && (!ls_inst_valid || (ls_is_load && bad_op_s));
    misalign_s = !bubble_s && ls_is_load && misaligned_s;
    ebreak_s   = !bubble_s && ls_ebreak;
    reason_s   = fault_reason(illegal_s, misalign_s, ebreak_s);
    commit_s   = !bubble_s && (reason_s != HR_ILLEGAL) && (reason_s != HR_MISALIGN);
    we_s       = commit_s && ls_rf_we && (ls_rf_waddr != 5'd0) && !ls_ebreak;
    wdata_s    = ls_is_load ? ld_data_s : ls_alu_res;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: any fault on an accepted packet halts until reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s && (reason_s != HR_NONE)) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs, decoded from the state register.
  always_comb begin
    wb_ready = 1'b0;
    halted   = 1'b0;
    case (state_q)
      ST_RUN:  wb_ready = 1'b1;
      ST_HALT: halted   = 1'b1;
      default: wb_ready = 1'b0;
    endcase
  end

  // Output registers: capture on accept, valid strobes last one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q       <= 1'b0;
      commit_q      <= 1'b0;
      waddr_q       <= 5'd0;
      wdata_q       <= '0;
      pc_q          <= '0;
      inst_q        <= 32'd0;
      cnt_q         <= '0;
      halt_reason_q <= HR_NONE;
    end else if (accept_s) begin
      rf_we_q  <= we_s;
      commit_q <= commit_s;
      waddr_q  <= ls_rf_waddr;
      wdata_q  <= wdata_s;
      pc_q     <= ls_pc;
      inst_q   <= ls_inst;
      cnt_q    <= cnt_q + CNT_W'(commit_s);
      if (reason_s != HR_NONE) begin
        halt_reason_q <= reason_s;
      end
    end else begin
      rf_we_q  <= 1'b0;
      commit_q <= 1'b0;
    end
  end

  assign rf_we        = rf_we_q;
  assign fwd_valid    = rf_we_q;
  assign rf_waddr     = waddr_q;
  assign rf_wdata     = wdata_q;
  assign commit_valid = commit_q;
  assign commit_pc    = pc_q;
  assign commit_inst  = inst_q;
  assign retired_cnt  = cnt_q;
  assign halt_reason  = halt_reason_q;

endmodule

// File: tb/tb_ysyx22041405_wb_stage.sv
// Directed self-checking bench: a 32-bit instance exercises the main paths,
// a 64-bit instance sharing the same stimulus checks the 64-bit-only loads.
module tb_ysyx22041405_wb_stage;
  import ysyx22041405_wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ls_valid = 1'b0;
  logic [31:0] ls_pc = 32'd0;
  logic [31:0] ls_inst = 32'd0;
  logic        ls_rf_we = 1'b0;
  logic [4:0]  ls_rf_waddr = 5'd0;
  logic [63:0] ls_alu_res = 64'd0;
  logic        ls_is_load = 1'b0;
  logic [2:0]  ls_mem_op = 3'd0;
  logic [2:0]  ls_addr_lo = 3'd0;
  logic [63:0] ls_dm_rdata = 64'd0;
  logic        ls_ebreak = 1'b0;
  logic        ls_inst_valid = 1'b1;

  logic        a_ready, a_we, a_fwd, a_commit, a_halted;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata, a_cpc, a_cinst;
  logic [63:0] a_cnt;
  logic [1:0]  a_reason;

  logic        b_ready, b_we, b_fwd, b_commit, b_halted;
  logic [4:0]  b_waddr;
  logic [63:0] b_wdata;
  logic [31:0] b_cpc, b_cinst;
  logic [63:0] b_cnt;
  logic [1:0]  b_reason;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_cnt = 64'd0;

  always #5 clk = ~clk;

  ysyx22041405_wb_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .wb_ready(a_ready),
    .ls_pc(ls_pc), .ls_inst(ls_inst), .ls_rf_we(ls_rf_we),
    .ls_rf_waddr(ls_rf_waddr), .ls_alu_res(ls_alu_res[31:0]),
    .ls_is_load(ls_is_load), .ls_mem_op(ls_mem_op), .ls_addr_lo(ls_addr_lo),
    .ls_dm_rdata(ls_dm_rdata[31:0]), .ls_ebreak(ls_ebreak),
    .ls_inst_valid(ls_inst_valid), .rf_we(a_we), .rf_waddr(a_waddr),
    .rf_wdata(a_wdata), .fwd_valid(a_fwd), .commit_valid(a_commit),
    .commit_pc(a_cpc), .commit_inst(a_cinst), .retired_cnt(a_cnt),
    .halted(a_halted), .halt_reason(a_reason)
  );

  ysyx22041405_wb_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .wb_ready(b_ready),
    .ls_pc(ls_pc), .ls_inst(ls_inst), .ls_rf_we(ls_rf_we),
    .ls_rf_waddr(ls_rf_waddr), .ls_alu_res(ls_alu_res),
    .ls_is_load(ls_is_load), .ls_mem_op(ls_mem_op), .ls_addr_lo(ls_addr_lo),
    .ls_dm_rdata(ls_dm_rdata), .ls_ebreak(ls_ebreak),
    .ls_inst_valid(ls_inst_valid), .rf_we(b_we), .rf_waddr(b_waddr),
    .rf_wdata(b_wdata), .fwd_valid(b_fwd), .commit_valid(b_commit),
    .commit_pc(b_cpc), .commit_inst(b_cinst), .retired_cnt(b_cnt),
    .halted(b_halted), .halt_reason(b_reason)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pkt(input logic [31:0] inst, input logic we, input logic [4:0] rd,
                     input logic [63:0] alu, input logic ld, input logic [2:0] op,
                     input logic [2:0] lo, input logic [63:0] rdv,
                     input logic eb, input logic iv);
    ls_valid      = 1'b1;
    ls_pc         = ls_pc + 32'd4;
    ls_inst       = inst;
    ls_rf_we      = we;
    ls_rf_waddr   = rd;
    ls_alu_res    = alu;
    ls_is_load    = ld;
    ls_mem_op     = op;
    ls_addr_lo    = lo;
    ls_dm_rdata   = rdv;
    ls_ebreak     = eb;
    ls_inst_valid = iv;
  endtask

  task automatic idle();
    ls_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 64'd0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".we"},     a_we,     1'b0);
    chk({tag, ".fwd"},    a_fwd,    1'b0);
    chk({tag, ".waddr"},  a_waddr,  5'd0);
    chk({tag, ".wdata"},  a_wdata,  32'd0);
    chk({tag, ".commit"}, a_commit, 1'b0);
    chk({tag, ".cpc"},    a_cpc,    32'd0);
    chk({tag, ".cinst"},  a_cinst,  32'd0);
    chk({tag, ".cnt"},    a_cnt,    64'd0);
    chk({tag, ".halted"}, a_halted, 1'b0);
    chk({tag, ".reason"}, a_reason, 2'b00);
    chk({tag, ".ready"},  a_ready,  1'b1);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk_reset("rst0");

    // LB, addr_lo=3: byte 0x80 sign-extended
    pkt(32'h0031_8283, 1'b1, 5'd5, 64'd0, 1'b1, OP_LB, 3'd3, 64'h80FF_1234, 1'b0, 1'b1);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("lb.we", a_we, 1'b1);
    chk("lb.fwd", a_fwd, 1'b1);
    chk("lb.waddr", a_waddr, 5'd5);
    chk("lb.wdata", a_wdata, 32'hFFFF_FF80);
    chk("lb.commit", a_commit, 1'b1);
    chk("lb.cpc", a_cpc, 32'd4);
    chk("lb.cinst", a_cinst, 32'h0031_8283);
    chk("lb.cnt", a_cnt, exp_cnt);

    // LHU, addr_lo=2 (back-to-back)
    pkt(32'h0023_5303, 1'b1, 5'd6, 64'd0, 1'b1, OP_LHU, 3'd2, 64'hBEEF_0000, 1'b0, 1'b1);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("lhu.wdata", a_wdata, 32'h0000_BEEF);
    chk("lhu.waddr", a_waddr, 5'd6);
    chk("lhu.cnt", a_cnt, exp_cnt);

    // LBU, addr_lo=1: no sign extension of 0x80
    pkt(32'h0014_c383, 1'b1, 5'd7, 64'd0, 1'b1, OP_LBU, 3'd1, 64'h0000_8000, 1'b0, 1'b1);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("lbu.wdata", a_wdata, 32'h0000_0080);

    // LH, addr_lo=2: halfword 0x8001 sign-extended
    pkt(32'h0021_9403, 1'b1, 5'd8, 64'd0, 1'b1, OP_LH, 3'd2, 64'h8001_0000, 1'b0, 1'b1);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("lh.wdata", a_wdata, 32'hFFFF_8001);

    // LW, addr_lo=0
    pkt(32'h0001_a483, 1'b1, 5'd9, 64'd0, 1'b1, OP_LW, 3'd0, 64'h89AB_CDEF, 1'b0, 1'b1);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("lw.wdata", a_wdata, 32'h89AB_CDEF);
    chk("lw.cnt", a_cnt, exp_cnt);

    // Strobes last one cycle only
    idle();
    tick();
    chk("idle.we", a_we, 1'b0);
    chk("idle.commit", a_commit, 1'b0);
    chk("idle.cnt", a_cnt, exp_cnt);

    // Four back-to-back ALU packets, rd=0..3
    for (int i = 0; i < 4; i++) begin
      pkt(32'h0000_0013 + 32'(i << 7), 1'b1, 5'(i), 64'h1000 + 64'(i), 1'b0, OP_LB, 3'd0, 64'd0, 1'b0, 1'b1);
      tick();
      exp_cnt = exp_cnt + 64'd1;
      chk($sformatf("alu%0d.we", i), a_we, (i != 0) ? 1'b1 : 1'b0);
      chk($sformatf("alu%0d.commit", i), a_commit, 1'b1);
      chk($sformatf("alu%0d.wdata", i), a_wdata, 32'h1000 + 32'(i));
      chk($sformatf("alu%0d.cnt", i), a_cnt, exp_cnt);
    end

    // Bubble: no commit, no write
    pkt(32'd0, 1'b1, 5'd7, 64'h55, 1'b0, OP_LB, 3'd0, 64'd0, 1'b0, 1'b1);
    tick();
    chk("bub.we", a_we, 1'b0);
    chk("bub.commit", a_commit, 1'b0);
    chk("bub.cnt", a_cnt, exp_cnt);
    chk("bub.ready", a_ready, 1'b1);

    // LH at addr_lo=1: misaligned halt
    pkt(32'h0011_9503, 1'b1, 5'd10, 64'd0, 1'b1, OP_LH, 3'd1, 64'h1234_5678, 1'b0, 1'b1);
    tick();
    chk("mis.we", a_we, 1'b0);
    chk("mis.commit", a_commit, 1'b0);
    chk("mis.halted", a_halted, 1'b1);
    chk("mis.reason", a_reason, 2'b11);
    chk("mis.ready", a_ready, 1'b0);
    chk("mis.cnt", a_cnt, exp_cnt);

    // Reset from HALT
    do_reset();
    chk_reset("rst1");

    // ebreak commits and halts; following packet refused
    pkt(32'h0010_0073, 1'b1, 5'd9, 64'h77, 1'b0, OP_LB, 3'd0, 64'd0, 1'b1, 1'b1);
    tick();
    exp_cnt = exp_cnt + 64'd1;
    chk("eb.commit", a_commit, 1'b1);
    chk("eb.we", a_we, 1'b0);
    chk("eb.reason", a_reason, 2'b01);
    chk("eb.halted", a_halted, 1'b1);
    chk("eb.ready", a_ready, 1'b0);
    chk("eb.cnt", a_cnt, exp_cnt);
    pkt(32'h0050_0593, 1'b1, 5'd11, 64'h99, 1'b0, OP_LB, 3'd0, 64'd0, 1'b0, 1'b1);
    tick();
    chk("ebnext.commit", a_commit, 1'b0);
    chk("ebnext.we", a_we, 1'b0);
    chk("ebnext.cnt", a_cnt, exp_cnt);
    chk("ebnext.reason", a_reason, 2'b01);

    // Illegal instruction
    do_reset();
    pkt(32'h0000_FFFF, 1'b1, 5'd12, 64'h1, 1'b0, OP_LB, 3'd0, 64'd0, 1'b0, 1'b0);
    tick();
    chk("ill.commit", a_commit, 1'b0);
    chk("ill.we", a_we, 1'b0);
    chk("ill.reason", a_reason, 2'b10);
    chk("ill.halted", a_halted, 1'b1);
    do_reset();
    chk_reset("rst2");

    // LD is illegal on the 32-bit datapath
    pkt(32'h0001_b603, 1'b1, 5'd12, 64'd0, 1'b1, OP_LD, 3'd0, 64'h1, 1'b0, 1'b1);
    tick();
    chk("ld32.reason", a_reason, 2'b10);
    chk("ld32.commit", a_commit, 1'b0);
    do_reset();

    // 64-bit loads on the XLEN=64 instance
    pkt(32'h0001_b603, 1'b1, 5'd12, 64'd0, 1'b1, OP_LD, 3'd0, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
    tick();
    chk("ld64.wdata", b_wdata, 64'h8000_0000_0000_0001);
    chk("ld64.we", b_we, 1'b1);
    chk("ld64.commit", b_commit, 1'b1);
    pkt(32'h0001_e603, 1'b1, 5'd12, 64'd0, 1'b1, OP_LWU, 3'd0, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
    tick();
    chk("lwu64.wdata", b_wdata, 64'h0000_0000_0000_0001);
    pkt(32'h0041_a603, 1'b1, 5'd12, 64'd0, 1'b1, OP_LW, 3'd4, 64'h8000_0000_0000_0001, 1'b0, 1'b1);
    tick();
    chk("lw64.wdata", b_wdata, 64'hFFFF_FFFF_8000_0000);
    pkt(32'h0061_d603, 1'b1, 5'd12, 64'd0, 1'b1, OP_LHU, 3'd6, 64'hBEEF_0000_0000_0000, 1'b0, 1'b1);
    tick();
    chk("lhu64.wdata", b_wdata, 64'h0000_0000_0000_BEEF);
    chk("lhu64.cnt", b_cnt, 64'd4);
    pkt(32'h0041_b603, 1'b1, 5'd12, 64'd0, 1'b1, OP_LD, 3'd4, 64'h1, 1'b0, 1'b1);
    tick();
    chk("ld64mis.reason", b_reason, 2'b11);
    chk("ld64mis.we", b_we, 1'b0);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
